// File: rtl/mem_arb_pkg.sv
// Shared state encoding and mux select constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count register: clear, increment, hold once MAX_VAL is reached.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(MAX_VAL))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// sequences each access and aborts accesses that never see mem_ready.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic d_we,
    input  logic mem_ready,
    output logic mem_sel,
    output logic mem_en,
    output logic mem_we,
    output logic if_done,
    output logic d_done,
    output logic timeout_err
);

    state_t             state;
    state_t             next_state;
    logic               grant_data;
    logic               grant_fetch;
    logic               access;
    logic               timeout_hit;
    logic               we_q;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   wait_cnt;

    // Arbitration: data wins unless fetch has been starved STARVE_LIMIT times.
    assign grant_data  = (state == S_IDLE) && d_req &&
                         (!if_req || (starve_cnt < CNT_W'(STARVE_LIMIT)));
    assign grant_fetch = (state == S_IDLE) && !grant_data && if_req;
    assign access      = (state == S_FETCH) || (state == S_DATA);

    // wait_cnt is 0 in the first access cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
    assign timeout_hit = access && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Consecutive data grants taken while fetch was waiting.
    arb_sat_counter #(
        .CNT_W   (CNT_W),
        .MAX_VAL (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .clr (grant_fetch),
        .inc (grant_data && if_req),
        .cnt (starve_cnt)
    );

    // Cycles spent in the current access; held at zero while idle.
    arb_sat_counter #(
        .CNT_W   (CNT_W),
        .MAX_VAL (TIMEOUT)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .inc (access),
        .cnt (wait_cnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: grant from idle, return to idle on ready or timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (grant_data) begin
                    next_state = S_DATA;
                end else if (grant_fetch) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ready || timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode; done pulses are suppressed in a reset cycle so an aborted access never completes.
    always_comb begin
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        if_done = 1'b0;
        d_done  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_en  = 1'b1;
                if_done = mem_ready && rst;
            end
            S_DATA: begin
                mem_en  = 1'b1;
                mem_we  = we_q;
                d_done  = mem_ready && rst;
            end
            default: ;
        endcase
    end

    // Grant registers: mux select and write flag are frozen for the whole access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_sel <= SEL_FETCH;
            we_q    <= 1'b0;
        end else if (grant_data) begin
            mem_sel <= SEL_DATA;
            we_q    <= d_we;
        end else if (grant_fetch) begin
            mem_sel <= SEL_FETCH;
            we_q    <= d_we;
        end
    end

    // Sticky timeout flag; ready in the final cycle takes precedence over the abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end

endmodule
